cic_dec96: RTL and testbench
============================

Name: cic_dec96

Overview:
- Avalon-ST CIC decimator, factor 96: the down-rate counterpart of the up-by-96 interpolator in the rate-converter library.
- Takes 16-bit signed PCM at the high internal rate and returns 16-bit signed PCM at 1/96 of the accepted-sample rate.
- Sits in the audio capture/rate-converter path ahead of the mixer's low-rate domain.
- Hand-written RTL with the same sink/source signal set as the library IP.

Parameters:
- R, 96: decimation factor (accepted inputs per output).
- N, 4: number of integrator stages and number of comb stages. Differential delay M is fixed at 1.
- DW, 16: input and output sample width, two's complement.
- SHIFT, 27: output right-shift. Must be at least ceil(N*log2 R). With the defaults, gain = 96^4/2^27 = 81/128.
- ACCW, DW+SHIFT (43): width of the integrator and comb datapath.

Ports:
- clk  in  1  single clock for the whole block.
- reset_n  in  1  synchronous, active-low reset.
- in_data  in  DW  signed input sample.
- in_valid  in  1  sink valid.
- in_ready  out  1  sink ready.
- in_startofpacket  in  1  realigns the decimation phase.
- in_endofpacket  in  1  packet end marker.
- in_error  in  2  per-sample error flags.
- out_data  out  DW  signed decimated sample.
- out_valid  out  1  source valid.
- out_ready  in  1  source ready.
- out_startofpacket  out  1  first output of a packet.
- out_endofpacket  out  1  output whose window contained the input EOP.
- out_error  out  2  OR of in_error over the output's window.
- out_channel  out  1  constant 0.

Behaviour:
- Reset (reset_n low at a rising edge): clears all integrators, comb delays, the phase counter, the output register, and the sticky SOP/EOP/error flags. out_valid, out_data, out_error, out_startofpacket and out_endofpacket are all 0 after reset. in_ready is 1 after reset. A reset mid-window discards the partial window; no output is produced for it.
- Accept rule: an input is accepted when in_valid & in_ready. in_ready = ~(out_valid & ~out_ready). Input therefore stalls only while a finished output is held and not yet taken.
- Integrators: on each accepted beat, I1 += sign-extended in_data, and Ik += I(k-1) for k = 2..N. Use the pre-update value of I(k-1) (a pipelined integrator chain). Arithmetic is ACCW-bit wrap-around; overflow is intentional and cancelled by the combs.
- Phase counter: counts 0..R-1, advances per accepted beat, and wraps from R-1 to 0.
  - If in_startofpacket is set on an accepted beat, the phase is forced so that this beat is phase 0.
  - Integrator contents are not cleared on SOP.
- Decimation event: an accepted beat with phase R-1.
  - Combs run in the same clock as the event: C1 = IN - D1, Ck = C(k-1) - Dk. IN is I_N including this beat's update; each Dk updates to its own stage input.
  - The result is registered into out_data = C_N[SHIFT+DW-1:SHIFT], i.e. an arithmetic right shift that floors. No saturation; with |gain| < 1 none is needed.
  - out_valid rises on the following clock. Latency from the R-th accepted beat to out_valid is 1 clock.
- Sideband per window:
  - out_error = OR of in_error over all accepted beats in the window.
  - out_endofpacket = 1 if any accepted beat in the window had in_endofpacket.
  - out_startofpacket = 1 on the first output after reset or after an accepted SOP.
  - The sticky flags clear at the decimation event. Flags from the event beat itself belong to the closing window.
- Output hold: out_data and sideband stay stable while out_valid & ~out_ready. out_valid falls after the handshake unless a new event fires in the same clock.
  - A same-clock event is possible because in_ready is high whenever out_ready is high.
  - If handshake and a new event coincide, load the new result and keep out_valid = 1.
- Backpressure during a window: integrators are frozen on cycles with no accepted beat.

Decomposition:
- Package cic_pkg: CIC_R, CIC_N, CIC_SHIFT, and the ACCW computation function, shared with the interpolator wrapper and the testbench.
- One natural sub-module, cic_comb_stage: a registered delay plus a subtractor. Instantiate it N times via generate. Integrators stay inline.

Test Plan:
- DC: 2000 accepted beats of in_data = 1000 with out_ready = 1 → after N windows, every output = 632; exactly 20 outputs; each out_valid 1 clock after every 96th beat.
- DC extremes: +32767 → steady 20735; -32768 → steady -20736; -1000 → -633. Confirms floor rounding and wrap-safe integrators.
- Backpressure: hold out_ready = 0 at an event → in_ready = 0 the next clock, out_data stable. Release → handshake; the next window completes after another 96 beats; no samples lost (total beat count unchanged).
- SOP realign: SOP on beat 40 of a window → next output after beat 40+95, with out_startofpacket = 1. EOP on beat 10 of a window → that window's output has out_endofpacket = 1, the next has 0.
- Error: in_error = 2'b01 on one beat and 2'b10 on another in the same window → out_error = 2'b11 for that output, 2'b00 for the next.
- Reset mid-window: assert reset_n = 0 after 50 beats → all outputs 0, in_ready = 1. Restart DC 1000 → matches a fresh-start golden model sample-for-sample.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared constants for the CIC rate-converter family (decimator, interpolator, benches).
package cic_pkg;

  localparam int CIC_R     = 96;
  localparam int CIC_N     = 4;
  localparam int CIC_DW    = 16;
  localparam int CIC_SHIFT = 27;

  // Datapath width: the sample width plus the worst-case bit growth
  // (SHIFT is chosen to be at least ceil(N*log2 R)).
  function automatic int cic_accw(input int dw, input int shift);
    return dw + shift;
  endfunction

  localparam int CIC_ACCW = cic_accw(CIC_DW, CIC_SHIFT);

endpackage

// File: rtl/cic_dec96_if.sv
// Avalon-ST sink and source signal set of the decimator, bundled in one interface.
interface cic_dec96_if #(
  parameter int DW = 16
) ();

  // sink side
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          in_startofpacket;
  logic          in_endofpacket;
  logic [1:0]    in_error;

  // source side
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_startofpacket;
  logic          out_endofpacket;
  logic [1:0]    out_error;
  logic          out_channel;

  // upstream producer / downstream consumer seen from outside the block
  modport master (
    output in_data, in_valid, in_startofpacket, in_endofpacket, in_error, out_ready,
    input  in_ready, out_data, out_valid, out_startofpacket, out_endofpacket,
           out_error, out_channel
  );

  // the decimator itself
  modport slave (
    input  in_data, in_valid, in_startofpacket, in_endofpacket, in_error, out_ready,
    output in_ready, out_data, out_valid, out_startofpacket, out_endofpacket,
           out_error, out_channel
  );

endinterface

// File: rtl/cic_comb_stage.sv
// One CIC comb section (M = 1): output is the input minus the input seen at the
// previous decimation event.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = CIC_ACCW
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] delay_reg;

  // Capture this stage's input once per decimation event.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      delay_reg <= '0;
    end else if (en) begin
      delay_reg <= din;
    end
  end

  assign dout = din - delay_reg;

endmodule

// File: rtl/cic_dec96.sv
// CIC decimator, factor R, N stages, M = 1, Avalon-ST sink/source.
// Integrators run at the accepted-input rate; combs evaluate combinationally on the
// decimation beat and the result is registered into a held output word.
module cic_dec96
  import cic_pkg::*;
#(
  parameter int R     = CIC_R,
  parameter int N     = CIC_N,
  parameter int DW    = CIC_DW,
  parameter int SHIFT = CIC_SHIFT,
  parameter int ACCW  = cic_accw(DW, SHIFT)
) (
  input  logic        clk,
  input  logic        reset_n,
  cic_dec96_if.slave  bus
);

  localparam int PW = $clog2(R);

  logic [PW-1:0]         phase_reg;
  logic [PW-1:0]         phase_eff;
  logic                  accept;
  logic                  event_fire;
  logic                  handshake;
  logic [ACCW-1:0]       in_ext;
  logic [ACCW-1:0]       integ_reg  [N];
  logic [ACCW-1:0]       integ_next [N];
  logic [N:0][ACCW-1:0]  comb_chain;
  logic                  unused_low;

  logic                  sop_pend_reg;
  logic                  eop_acc_reg;
  logic [1:0]            err_acc_reg;
  logic                  win_sop;
  logic                  win_eop;
  logic [1:0]            win_err;

  logic [DW-1:0]         out_data_reg;
  logic                  out_valid_reg;
  logic                  out_sop_reg;
  logic                  out_eop_reg;
  logic [1:0]            out_err_reg;

  // Input stalls only while a finished output is held and not taken.
  assign bus.in_ready = ~(out_valid_reg & ~bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign handshake    = out_valid_reg & bus.out_ready;

  // An SOP beat is treated as phase 0 of a fresh window.
  assign phase_eff  = bus.in_startofpacket ? '0 : phase_reg;
  assign event_fire = accept & (phase_eff == PW'(R - 1));

  assign in_ext = {{(ACCW - DW){bus.in_data[DW-1]}}, bus.in_data};

  // Pipelined integrator chain: each stage adds the previous stage's old value.
  always_comb begin
    integ_next[0] = integ_reg[0] + in_ext;
    for (int k = 1; k < N; k++) begin
      integ_next[k] = integ_reg[k] + integ_reg[k-1];
    end
  end

  // Integrators advance only on accepted beats; wrap-around is cancelled by the combs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) begin
        integ_reg[k] <= '0;
      end
    end else if (accept) begin
      for (int k = 0; k < N; k++) begin
        integ_reg[k] <= integ_next[k];
      end
    end
  end

  // Comb cascade fed with the last integrator including this beat's update.
  assign comb_chain[0] = integ_next[N-1];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_comb
      cic_comb_stage #(
        .W (ACCW)
      ) u_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (event_fire),
        .din     (comb_chain[gi]),
        .dout    (comb_chain[gi+1])
      );
    end
  endgenerate

  // Fractional bits dropped by the floor shift.
  assign unused_low = ^comb_chain[N][SHIFT-1:0];

  // Phase counter 0..R-1 over accepted beats, realigned by SOP.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_reg <= '0;
    end else if (accept) begin
      phase_reg <= event_fire ? '0 : phase_eff + 1'b1;
    end
  end

  // Window sideband includes the flags carried by the event beat itself.
  assign win_sop = sop_pend_reg | bus.in_startofpacket;
  assign win_eop = eop_acc_reg  | bus.in_endofpacket;
  assign win_err = err_acc_reg  | bus.in_error;

  // Sticky window flags; reset arms SOP so the first output is marked.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sop_pend_reg <= 1'b1;
      eop_acc_reg  <= 1'b0;
      err_acc_reg  <= 2'b00;
    end else if (accept) begin
      if (event_fire) begin
        sop_pend_reg <= 1'b0;
        eop_acc_reg  <= 1'b0;
        err_acc_reg  <= 2'b00;
      end else begin
        sop_pend_reg <= win_sop;
        eop_acc_reg  <= win_eop;
        err_acc_reg  <= win_err;
      end
    end
  end

  // Output word: load on event (even in a handshake clock), otherwise hold until taken.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sop_reg   <= 1'b0;
      out_eop_reg   <= 1'b0;
      out_err_reg   <= 2'b00;
    end else if (event_fire) begin
      out_data_reg  <= comb_chain[N][SHIFT+DW-1:SHIFT];
      out_valid_reg <= 1'b1;
      out_sop_reg   <= win_sop;
      out_eop_reg   <= win_eop;
      out_err_reg   <= win_err;
    end else if (handshake) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_data          = out_data_reg;
  assign bus.out_valid         = out_valid_reg;
  assign bus.out_startofpacket = out_sop_reg;
  assign bus.out_endofpacket   = out_eop_reg;
  assign bus.out_error         = out_err_reg;
  assign bus.out_channel       = 1'b0;

endmodule

// File: tb/tb_cic_dec96.sv
// Bench for cic_dec96: stimulus process feeds a closed-form CIC model and queues
// expected outputs; a monitor pops and compares on every output handshake.
module tb_cic_dec96;
  import cic_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cic_dec96_if #(.DW(CIC_DW)) bus ();

  cic_dec96 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  err;
  } exp_t;

  exp_t   exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     n_out = 0;
  int     beats = 0;
  logic signed [15:0] last_data;
  bit     in_reset = 1'b1;
  bit     lat_pending = 1'b0;

  // reference model state
  longint xs[$];
  longint hist[4];
  int     phase_m;
  logic   sop_m, eop_m;
  logic [1:0] err_m;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint binom3(input longint m);
    if (m < 3) return 0;
    return m * (m - 1) * (m - 2) / 6;
  endfunction

  task automatic model_reset();
    xs.delete();
    for (int i = 0; i < 4; i++) hist[i] = 0;
    phase_m = 0;
    sop_m = 1'b1;
    eop_m = 1'b0;
    err_m = 2'b00;
    exp_q.delete();
    lat_pending = 1'b0;
  endtask

  // Last-integrator value after beat n is sum x[j]*C(n-j,3) (pipelined chain adds
  // a 3-beat delay); the output is the 4th difference of those values taken at the
  // decimation beats, reduced modulo 2^ACCW and floored by 2^SHIFT.
  task automatic model_accept(input logic [15:0] d, input logic sop, input logic eop,
                              input logic [1:0] err);
    longint n, i4, y, w;
    logic [63:0] yb;
    exp_t e;
    n = longint'(xs.size());
    xs.push_back(longint'($signed(d)));
    if (sop) phase_m = 0;
    sop_m = sop_m | sop;
    eop_m = eop_m | eop;
    err_m = err_m | err;
    if (phase_m == CIC_R - 1) begin
      i4 = 0;
      for (int j = 0; j <= int'(n); j++) i4 += xs[j] * binom3(n - longint'(j));
      y = i4 - 4 * hist[0] + 6 * hist[1] - 4 * hist[2] + hist[3];
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = i4;
      yb = y;
      w = $signed(yb << (64 - CIC_ACCW)) >>> (64 - CIC_ACCW);
      e.data = 16'(w >>> CIC_SHIFT);
      e.sop = sop_m;
      e.eop = eop_m;
      e.err = err_m;
      exp_q.push_back(e);
      sop_m = 1'b0;
      eop_m = 1'b0;
      err_m = 2'b00;
      phase_m = 0;
      lat_pending = 1'b1;
    end else begin
      phase_m++;
    end
  endtask

  task automatic step(input logic [15:0] d, input logic v, input logic sop,
                      input logic eop, input logic [1:0] err, input logic rdy);
    @(posedge clk);
    #1;
    bus.in_data = d;
    bus.in_valid = v;
    bus.in_startofpacket = sop;
    bus.in_endofpacket = eop;
    bus.in_error = err;
    bus.out_ready = rdy;
    @(negedge clk);
    if (lat_pending) begin
      chk("latency_valid", longint'(bus.out_valid), 1);
      lat_pending = 1'b0;
    end
    if (bus.in_valid && bus.in_ready) begin
      beats++;
      model_accept(d, sop, eop, err);
    end
  endtask

  task automatic drain();
    repeat (4) step(16'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    chk("drain_queue_empty", longint'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_startofpacket = 1'b0;
    bus.in_endofpacket = 1'b0;
    bus.in_error = 2'b00;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    n_out = 0;
    beats = 0;
    @(negedge clk);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_data", longint'(bus.out_data), 0);
    chk("rst_out_error", longint'(bus.out_error), 0);
    chk("rst_out_sop_eop", longint'({bus.out_startofpacket, bus.out_endofpacket}), 0);
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    in_reset = 1'b0;
  endtask

  // Monitor: compare each accepted output, check hold stability and stall.
  bit          hold = 1'b0;
  logic [15:0] hold_data;
  logic [3:0]  hold_side;
  initial begin
    forever begin
      @(negedge clk);
      if (in_reset) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        chk("hold_valid", longint'(bus.out_valid), 1);
        chk("hold_data", longint'(bus.out_data), longint'(hold_data));
        chk("hold_side", longint'({bus.out_startofpacket, bus.out_endofpacket, bus.out_error}),
            longint'(hold_side));
      end
      if (bus.out_valid && !bus.out_ready) begin
        chk("stall_in_ready", longint'(bus.in_ready), 0);
        hold = 1'b1;
        hold_data = bus.out_data;
        hold_side = {bus.out_startofpacket, bus.out_endofpacket, bus.out_error};
      end else begin
        hold = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("out_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          n_out++;
          last_data = bus.out_data;
          $display("out %0d: data=%0d (exp %0d) sop=%0b eop=%0b err=%b",
                   n_out, $signed(bus.out_data), $signed(e.data),
                   bus.out_startofpacket, bus.out_endofpacket, bus.out_error);
          chk("out_data", longint'($signed(bus.out_data)), longint'($signed(e.data)));
          chk("out_sop", longint'(bus.out_startofpacket), longint'(e.sop));
          chk("out_eop", longint'(bus.out_endofpacket), longint'(e.eop));
          chk("out_error", longint'(bus.out_error), longint'(e.err));
          chk("out_channel", longint'(bus.out_channel), 0);
        end
      end
    end
  end

  int dc_val [3] = '{32767, -32768, -1000};
  int dc_exp [3] = '{20735, -20736, -633};

  initial begin
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.in_startofpacket = 1'b0;
    bus.in_endofpacket = 1'b0;
    bus.in_error = 2'b00;
    bus.out_ready = 1'b0;

    // DC 1000: 2000 beats give exactly 20 outputs, steady at 632
    do_reset();
    repeat (2000) step(16'd1000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    drain();
    chk("dc1000_count", longint'(n_out), 20);
    chk("dc1000_steady", longint'(last_data), 632);

    // DC extremes
    for (int t = 0; t < 3; t++) begin
      do_reset();
      repeat (576) step(16'(dc_val[t]), 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
      drain();
      chk("dc_extreme_steady", longint'(last_data), longint'(dc_exp[t]));
    end

    // Backpressure across an event: no beats lost
    do_reset();
    repeat (96) step(16'($urandom), 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    repeat (5) step(16'($urandom), 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    repeat (96) step(16'($urandom), 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    drain();
    chk("bp_beats", longint'(beats), 192);
    chk("bp_outputs", longint'(n_out), 2);

    // SOP realign, EOP and error OR across windows
    do_reset();
    repeat (96) step(16'($urandom), 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    repeat (39) step(16'($urandom), 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    step(16'($urandom), 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    repeat (95) step(16'($urandom), 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    chk("sop_realign_outputs", longint'(exp_q.size() + n_out), 2);
    for (int b = 0; b < 96; b++) begin
      step(16'($urandom), 1'b1, 1'b0, (b == 9), (b == 5) ? 2'b01 : ((b == 50) ? 2'b10 : 2'b00),
           1'b1);
    end
    repeat (96) step(16'($urandom), 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    drain();
    chk("sop_eop_outputs", longint'(n_out), 4);

    // Randomized traffic with backpressure and sideband
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic       v, s, e, r;
      logic [1:0] er;
      v  = ($urandom_range(0, 9) < 8);
      s  = ($urandom_range(0, 399) == 0);
      e  = ($urandom_range(0, 59) == 0);
      er = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r  = ($urandom_range(0, 9) < 6);
      step(16'($urandom), v, s, e, er, r);
    end
    drain();

    // Reset mid-window, then a fresh DC 1000 run
    do_reset();
    repeat (50) step(16'd1000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    do_reset();
    repeat (576) step(16'd1000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    drain();
    chk("restart_count", longint'(n_out), 6);
    chk("restart_steady", longint'(last_data), 632);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
